// File: rtl/flit_pkg.sv
// Shared constants and types for the flit decoder.
//   LANE_W    : width of one encoded lane (invert flag + payload)
//   LANES     : lanes per flit
//   PAYLOAD_W : decoded payload bits per lane
//   DATA_W    : decoded payload bits per flit
//   entry_t   : one decoded flit as held in the output FIFO
package flit_pkg;

  localparam int unsigned LANE_W    = 8;
  localparam int unsigned LANES     = 4;
  localparam int unsigned PAYLOAD_W = 7;
  localparam int unsigned DATA_W    = LANES * PAYLOAD_W;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [LANES-1:0]  inv;
  } entry_t;

  // Number of set invert flags in one flit (0..4).
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/flit_decoder_lane_dec.sv
// Single-lane decoder (combinational).
//   lane : encoded lane, bit 7 = invert flag, bits 6:0 = lane data
//   data : decoded payload (lane data XOR replicated invert flag)
//   inv  : received invert flag
module lane_dec
  import flit_pkg::*;
(
  input  logic [LANE_W-1:0]    lane,
  output logic [PAYLOAD_W-1:0] data,
  output logic                 inv
);

  always_comb begin
    inv  = lane[LANE_W-1];
    data = lane[PAYLOAD_W-1:0] ^ {PAYLOAD_W{lane[LANE_W-1]}};
  end

endmodule

// File: rtl/flit_decoder.sv
// Flit decoder: decodes LANES inverted-lane encoded bytes per flit into a
// 2-entry output FIFO and keeps saturating flit / inverted-lane statistics.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : encoded flit handshake (in_ready is registered)
//   in_flit              : encoded flit, lane l in byte l
//   out_valid/out_ready  : decoded flit handshake
//   out_data, out_inv    : decoded payload (lane l at bits 7l+6:7l) and flags
//   clr_stats            : synchronous clear of both counters
//   flit_cnt, inv_cnt    : accepted flits / inverted lanes, saturating
module flit_decoder
  import flit_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*LANE_W-1:0]      in_flit,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*PAYLOAD_W-1:0]   out_data,
  output logic [LANES-1:0]             out_inv,
  input  logic                         clr_stats,
  output logic [CNT_W-1:0]             flit_cnt,
  output logic [CNT_W-1:0]             inv_cnt
);

  logic [LANES*PAYLOAD_W-1:0] dec_data;
  logic [LANES-1:0]           dec_inv;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    lane_dec u_lane (
      .lane (in_flit[l*LANE_W +: LANE_W]),
      .data (dec_data[l*PAYLOAD_W +: PAYLOAD_W]),
      .inv  (dec_inv[l])
    );
  end

  entry_t     mem [2];
  entry_t     mem_n [2];
  entry_t     dec_entry;
  entry_t     head_q;
  logic       rd_ptr, wr_ptr, rd_n, wr_n;
  logic [1:0] count, cnt_n;
  logic       ready_q;
  logic       push, pop;

  logic [CNT_W:0]   flit_sum, inv_sum;
  logic [CNT_W-1:0] flit_nxt, inv_nxt;

  always_comb begin
    dec_entry.data = dec_data;
    dec_entry.inv  = dec_inv;

    push = in_valid & ready_q;
    pop  = (count != 2'd0) & out_ready;

    mem_n[0] = mem[0];
    mem_n[1] = mem[1];
    if (push) mem_n[wr_ptr] = dec_entry;

    rd_n  = rd_ptr ^ pop;
    wr_n  = wr_ptr ^ push;
    cnt_n = count + {1'b0, push} - {1'b0, pop};

    flit_sum = {1'b0, flit_cnt} + (CNT_W+1)'(1);
    inv_sum  = {1'b0, inv_cnt} + (CNT_W+1)'(popcount4(dec_inv));
    flit_nxt = flit_sum[CNT_W] ? '1 : flit_sum[CNT_W-1:0];
    inv_nxt  = inv_sum[CNT_W]  ? '1 : inv_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= '0;
      ready_q  <= 1'b0;
      head_q   <= '0;
      flit_cnt <= '0;
      inv_cnt  <= '0;
    end else begin
      mem[0]  <= mem_n[0];
      mem[1]  <= mem_n[1];
      rd_ptr  <= rd_n;
      wr_ptr  <= wr_n;
      count   <= cnt_n;
      // in_ready is registered from next occupancy, so out_ready only
      // reaches it through this flop.
      ready_q <= (cnt_n != 2'd2);
      // Head is copied into its own register so the outputs hold the last
      // presented flit once the FIFO drains, instead of exposing a stale slot.
      if (cnt_n != 2'd0) head_q <= mem_n[rd_n];
      if (clr_stats) begin
        flit_cnt <= '0;
        inv_cnt  <= '0;
      end else if (push) begin
        flit_cnt <= flit_nxt;
        inv_cnt  <= inv_nxt;
      end
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = (count != 2'd0);
  assign out_data  = head_q.data;
  assign out_inv   = head_q.inv;

endmodule

// File: tb/tb_flit_decoder.sv
// Self-checking bench for flit_decoder: directed scenarios plus random
// round-trip traffic, checked against a queue-based behavioural model.
module tb_flit_decoder;

  typedef struct packed {
    logic [27:0] d;
    logic [3:0]  i;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, clr_stats;
  logic [31:0] in_flit;

  logic        in_ready, out_valid;
  logic [27:0] out_data;
  logic [3:0]  out_inv;
  logic [15:0] flit_cnt, inv_cnt;

  logic        s_in_ready, s_out_valid;
  logic [27:0] s_out_data;
  logic [3:0]  s_out_inv;
  logic [3:0]  s_flit_cnt, s_inv_cnt;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  exp_t        q[$];
  exp_t        last;
  bit          released;
  int unsigned m_fc, m_ic, s_fc, s_ic;

  always #5 clk = ~clk;

  flit_decoder #(.LANES(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_flit(in_flit), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_inv(out_inv), .clr_stats(clr_stats),
    .flit_cnt(flit_cnt), .inv_cnt(inv_cnt)
  );

  flit_decoder #(.LANES(4), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_flit(in_flit), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_inv(s_out_inv), .clr_stats(clr_stats),
    .flit_cnt(s_flit_cnt), .inv_cnt(s_inv_cnt)
  );

  function automatic exp_t decode_ref(input logic [31:0] f);
    exp_t e;
    for (int l = 0; l < 4; l++) begin
      e.i[l]        = f[8*l+7];
      e.d[7*l +: 7] = f[8*l +: 7] ^ {7{f[8*l+7]}};
    end
    return e;
  endfunction

  function automatic logic [31:0] encode(input logic [27:0] d, input logic [3:0] inv);
    logic [31:0] f;
    for (int l = 0; l < 4; l++) begin
      f[8*l+7]      = inv[l];
      f[8*l +: 7]   = d[7*l +: 7] ^ {7{inv[l]}};
    end
    return f;
  endfunction

  function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, then
  // advance the model by what the edge is supposed to do.
  task automatic step(input bit v, input logic [31:0] f, input exp_t e,
                      input bit ordy, input bit clr, input bit r);
    bit   ready_exp, acc, pop;
    exp_t head;
    rst = r; in_valid = v; in_flit = f; out_ready = ordy; clr_stats = clr;
    #1;
    ready_exp = released && (q.size() < 2);
    head      = (q.size() > 0) ? q[0] : last;
    if (released) begin
      chk("in_ready", in_ready, ready_exp);
      chk("sat_in_ready", s_in_ready, ready_exp);
    end
    chk("out_valid", out_valid, q.size() > 0);
    chk("out_data", out_data, head.d);
    chk("out_inv", out_inv, head.i);
    chk("flit_cnt", flit_cnt, m_fc);
    chk("inv_cnt", inv_cnt, m_ic);
    chk("sat_out_data", s_out_data, head.d);
    chk("sat_flit_cnt", s_flit_cnt, s_fc);
    chk("sat_inv_cnt", s_inv_cnt, s_ic);
    acc = v && ready_exp;
    pop = (q.size() > 0) && ordy;
    @(posedge clk);
    if (r) begin
      q.delete();
      last     = '0;
      released = 1'b0;
      m_fc = 0; m_ic = 0; s_fc = 0; s_ic = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(e);
      if (clr) begin
        m_fc = 0; m_ic = 0; s_fc = 0; s_ic = 0;
      end else if (acc) begin
        m_fc = sat(m_fc + 1, 65535);
        m_ic = sat(m_ic + $countones(e.i), 65535);
        s_fc = sat(s_fc + 1, 15);
        s_ic = sat(s_ic + $countones(e.i), 15);
      end
      released = 1'b1;
      if (q.size() > 0) last = q[0];
    end
    @(negedge clk);
  endtask

  task automatic rawstep(input bit v, input logic [31:0] f, input bit ordy, input bit clr);
    step(v, f, decode_ref(f), ordy, clr, 1'b0);
  endtask

  initial begin
    logic [31:0] fa, fb, fc, fx;
    logic [27:0] pd;
    logic [3:0]  pi;

    rst = 1'b1; in_valid = 1'b0; in_flit = '0; out_ready = 1'b0; clr_stats = 1'b0;
    last = '0; released = 1'b0; m_fc = 0; m_ic = 0; s_fc = 0; s_ic = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_inv", out_inv, 0);
    chk("rst_flit_cnt", flit_cnt, 0);
    chk("rst_inv_cnt", inv_cnt, 0);

    rawstep(1'b0, '0, 1'b1, 1'b0);
    rawstep(1'b0, '0, 1'b1, 1'b0);
    chk("ready_after_release", in_ready, 1);

    // Decode of a fixed flit
    rawstep(1'b1, 32'h00FF807F, 1'b1, 1'b0);
    chk("dec_out_valid", out_valid, 1);
    chk("dec_out_data", out_data, 28'h0003FFF);
    chk("dec_out_inv", out_inv, 4'b0110);
    chk("dec_flit_cnt", flit_cnt, 1);
    chk("dec_inv_cnt", inv_cnt, 2);
    rawstep(1'b0, '0, 1'b1, 1'b0);
    rawstep(1'b0, '0, 1'b1, 1'b0);

    // Backpressure: A, B fill the FIFO, C waits for space
    fa = $urandom; fb = $urandom; fc = $urandom;
    rawstep(1'b1, fa, 1'b0, 1'b0);
    rawstep(1'b1, fb, 1'b0, 1'b0);
    chk("bp_ready_full", in_ready, 0);
    rawstep(1'b1, fc, 1'b0, 1'b0);
    rawstep(1'b1, fc, 1'b0, 1'b0);
    chk("bp_head_is_a", out_data, decode_ref(fa).d);
    rawstep(1'b1, fc, 1'b1, 1'b0);
    rawstep(1'b1, fc, 1'b1, 1'b0);
    rawstep(1'b0, '0, 1'b1, 1'b0);
    rawstep(1'b0, '0, 1'b1, 1'b0);
    chk("bp_drained", out_valid, 0);
    chk("bp_last_is_c", out_data, decode_ref(fc).d);

    // Streaming 100 flits
    rawstep(1'b0, '0, 1'b1, 1'b1);
    for (int n = 0; n < 100; n++) rawstep(1'b1, $urandom, 1'b1, 1'b0);
    rawstep(1'b0, '0, 1'b1, 1'b0);
    chk("stream_flit_cnt", flit_cnt, 100);

    // Clear coincident with an acceptance
    rawstep(1'b1, 32'h80808080, 1'b1, 1'b1);
    chk("clr_flit_cnt", flit_cnt, 0);
    chk("clr_inv_cnt", inv_cnt, 0);
    chk("clr_out_valid", out_valid, 1);
    rawstep(1'b0, '0, 1'b1, 1'b0);

    // Reset with the FIFO full
    rawstep(1'b1, $urandom, 1'b0, 1'b0);
    rawstep(1'b1, $urandom, 1'b0, 1'b0);
    chk("full_out_valid", out_valid, 1);
    fx = $urandom;
    step(1'b1, fx, decode_ref(fx), 1'b1, 1'b0, 1'b1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_flit_cnt", flit_cnt, 0);
    chk("midrst_inv_cnt", inv_cnt, 0);
    chk("midrst_in_ready", in_ready, 0);
    rawstep(1'b0, '0, 1'b1, 1'b0);
    rawstep(1'b0, '0, 1'b1, 1'b0);

    // Saturation on the narrow-counter instance
    rawstep(1'b0, '0, 1'b1, 1'b1);
    for (int n = 0; n < 5; n++) rawstep(1'b1, 32'h80808080, 1'b1, 1'b0);
    rawstep(1'b0, '0, 1'b1, 1'b0);
    chk("sat_inv_15", s_inv_cnt, 15);
    chk("sat_flit_5", s_flit_cnt, 5);
    chk("wide_inv_20", inv_cnt, 20);
    rawstep(1'b1, 32'h80808080, 1'b1, 1'b0);
    rawstep(1'b0, '0, 1'b1, 1'b0);
    chk("sat_inv_hold", s_inv_cnt, 15);
    chk("sat_flit_6", s_flit_cnt, 6);

    // Random round trip with random handshakes
    for (int n = 0; n < 120; n++) begin
      pd = 28'($urandom);
      pi = 4'($urandom);
      step(1'($urandom), encode(pd, pi), '{d: pd, i: pi},
           ($urandom_range(0, 3) != 0), 1'b0, 1'b0);
    end
    for (int n = 0; n < 4; n++) rawstep(1'b0, '0, 1'b1, 1'b0);
    chk("final_empty", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
